// File: rtl/riscv_defines.sv
// Shared constants and types for the RISC-V core's APU path.
package riscv_defines;

    localparam int unsigned APU_NARGS   = 3;
    localparam int unsigned APU_WADDR_W = 6;
    localparam int unsigned APU_DATA_W  = 32;
    localparam int unsigned APU_FLAG_W  = 5;

    typedef struct packed {
        logic [APU_WADDR_W-1:0] waddr;
        logic [APU_DATA_W-1:0]  result;
        logic [APU_FLAG_W-1:0]  flags;
    } apu_wb_entry_t;

endpackage

// File: rtl/riscv_apu_wb_fifo.sv
// Generic in-order FIFO storage; exposes every slot and its validity for
// dependency comparison.
module riscv_apu_wb_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 43,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic [WIDTH-1:0]            data_i,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [WIDTH-1:0]            head_o,
    output logic [PTR_W-1:0]            head_idx_o,
    output logic [PTR_W:0]              count_o,
    output logic [DEPTH-1:0][WIDTH-1:0] entries_o,
    output logic [DEPTH-1:0]            valid_o
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [PTR_W-1:0]            rd_ptr_q;
    logic [PTR_W-1:0]            wr_ptr_q;
    logic [PTR_W:0]              count_q;

    // Storage needs no reset: a slot is only read while it is valid.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (PTR_W+1)'(push_i) - (PTR_W+1)'(pop_i);
        end
    end

    always_comb begin
        valid_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] offset;
            offset     = PTR_W'(i) - rd_ptr_q;
            valid_o[i] = ({1'b0, offset} < count_q);
        end
    end

    assign full_o     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign head_o     = mem_q[rd_ptr_q];
    assign head_idx_o = rd_ptr_q;
    assign count_o    = count_q;
    assign entries_o  = mem_q;

endmodule

// File: rtl/riscv_apu_wb_buffer.sv
// APU write-back buffer: bypasses results to regfile port B when free,
// otherwise queues them in order and reports dependencies and issue stalls.
module riscv_apu_wb_buffer
    import riscv_defines::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = APU_DATA_W,
    parameter int unsigned FLAG_W = APU_FLAG_W
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   apu_valid_i,
    input  logic [DATA_W-1:0]                      apu_result_i,
    input  logic [FLAG_W-1:0]                      apu_flags_i,
    input  logic [APU_WADDR_W-1:0]                 apu_waddr_i,
    input  logic                                   port_busy_i,
    output logic                                   regfile_we_o,
    output logic [APU_WADDR_W-1:0]                 regfile_waddr_o,
    output logic [DATA_W-1:0]                      regfile_wdata_o,
    output logic                                   fflags_we_o,
    output logic [FLAG_W-1:0]                      fflags_o,
    input  logic [APU_NARGS-1:0][APU_WADDR_W-1:0]  read_regs_i,
    input  logic [APU_NARGS-1:0]                   read_regs_valid_i,
    output logic                                   read_dep_o,
    output logic                                   stall_o,
    output logic                                   pending_o,
    output logic                                   overflow_o
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned ENTRY_W = APU_WADDR_W + DATA_W + FLAG_W;

    typedef struct packed {
        logic [APU_WADDR_W-1:0] waddr;
        logic [DATA_W-1:0]      result;
        logic [FLAG_W-1:0]      flags;
    } entry_t;

    entry_t                        in_entry;
    entry_t                        head_entry;
    logic [ENTRY_W-1:0]            head_data;
    logic [PTR_W-1:0]              head_idx;
    logic [PTR_W:0]                count;
    logic [DEPTH-1:0][ENTRY_W-1:0] fifo_entries;
    logic [DEPTH-1:0]              fifo_valid;
    logic                          full;
    logic                          empty;
    logic                          pop;
    logic                          bypass;
    logic                          push;
    logic                          push_accepted;
    logic                          overflow_q;

    assign in_entry      = '{waddr: apu_waddr_i, result: apu_result_i, flags: apu_flags_i};
    assign head_entry    = entry_t'(head_data);
    assign pop           = !empty && !port_busy_i;
    assign bypass        = apu_valid_i && empty && !port_busy_i;
    assign push          = apu_valid_i && !bypass;
    // A full FIFO can still take a result when its head leaves in the same cycle.
    assign push_accepted = push && (!full || pop);

    riscv_apu_wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (push_accepted),
        .pop_i      (pop),
        .data_i     (in_entry),
        .full_o     (full),
        .empty_o    (empty),
        .head_o     (head_data),
        .head_idx_o (head_idx),
        .count_o    (count),
        .entries_o  (fifo_entries),
        .valid_o    (fifo_valid)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                 overflow_q <= 1'b0;
        else if (push && !push_accepted) overflow_q <= 1'b1;
    end

    always_comb begin
        regfile_we_o    = 1'b0;
        regfile_waddr_o = '0;
        regfile_wdata_o = '0;
        fflags_o        = '0;
        if (pop) begin
            regfile_we_o    = 1'b1;
            regfile_waddr_o = head_entry.waddr;
            regfile_wdata_o = head_entry.result;
            fflags_o        = head_entry.flags;
        end else if (bypass) begin
            regfile_we_o    = 1'b1;
            regfile_waddr_o = apu_waddr_i;
            regfile_wdata_o = apu_result_i;
            fflags_o        = apu_flags_i;
        end
    end

    // The entry committing this cycle no longer blocks a reader.
    always_comb begin
        read_dep_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < APU_NARGS; j++) begin
                if (fifo_valid[i] && !(pop && head_idx == PTR_W'(i)) &&
                    read_regs_valid_i[j] &&
                    read_regs_i[j] == fifo_entries[i][ENTRY_W-1 -: APU_WADDR_W])
                    read_dep_o = 1'b1;
            end
        end
    end

    assign fflags_we_o = regfile_we_o;
    assign stall_o     = full || (count == (PTR_W+1)'(DEPTH - 1) && port_busy_i);
    assign pending_o   = !empty;
    assign overflow_o  = overflow_q;

endmodule
